// File: rtl/fc_argmax_if.sv
// Handshake and f8 RAM read bus between the classifier scan block and its environment.
// Optional max_score signal present only when FC_ARGMAX_SCORE_EN is defined.
interface fc_argmax_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              argmax_start;
  logic              f8_rd_en;
  logic [ADDR_W-1:0] f8_raddr;
  logic [DATA_W-1:0] f8_rdata;
  logic              busy;
  logic              argmax_done;
  logic [ADDR_W-1:0] class_id;
`ifdef FC_ARGMAX_SCORE_EN
  logic [DATA_W-1:0] max_score;

  modport master (
    input  argmax_start, f8_rdata,
    output f8_rd_en, f8_raddr, busy, argmax_done, class_id, max_score
  );
  modport slave (
    output argmax_start, f8_rdata,
    input  f8_rd_en, f8_raddr, busy, argmax_done, class_id, max_score
  );
`else
  modport master (
    input  argmax_start, f8_rdata,
    output f8_rd_en, f8_raddr, busy, argmax_done, class_id
  );
  modport slave (
    output argmax_start, f8_rdata,
    input  f8_rd_en, f8_raddr, busy, argmax_done, class_id
  );
`endif
endinterface

// File: rtl/fc_argmax.sv
// Scans the N_CLASS signed FC3 scores from the f8 RAM and reports the index of the largest.
// Define FC_ARGMAX_SCORE_EN to also export the winning score on max_score.
module fc_argmax #(
  parameter int DATA_W  = 16,
  parameter int N_CLASS = 10,
  parameter int ADDR_W  = 4,
  parameter int RD_LAT  = 1
) (
  input logic          clk,
  input logic          rst_n,
  fc_argmax_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    READ  = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [ADDR_W-1:0]        r_addr;
  logic [2:0]               r_drain_cnt;
  logic [RD_LAT-1:0]        r_vld_p;
  logic [ADDR_W-1:0]        r_idx_p [RD_LAT];
  logic signed [DATA_W-1:0] r_best_val, w_best_val_nxt;
  logic [ADDR_W-1:0]        r_best_idx, w_best_idx_nxt;
  logic [ADDR_W-1:0]        r_class_id;
  logic signed [DATA_W-1:0] w_rdata;
  logic                     w_vld, w_last_addr, w_drain_end, w_rd_en;
  logic [ADDR_W-1:0]        w_idx;

  // Index 0 always seeds the running maximum; later samples must be strictly larger,
  // which is what keeps the lowest index on a tie.
  function automatic logic beats(input logic signed [DATA_W-1:0] cand,
                                 input logic signed [DATA_W-1:0] best,
                                 input logic                     first);
    return first || (cand > best);
  endfunction

  assign w_rdata     = bus.f8_rdata;
  assign w_rd_en     = (r_state == READ);
  assign w_last_addr = (r_addr == ADDR_W'(N_CLASS - 1));
  assign w_drain_end = (r_drain_cnt == 3'(RD_LAT - 1));
  assign w_vld       = r_vld_p[RD_LAT-1];
  assign w_idx       = r_idx_p[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.argmax_start) w_state_nxt = READ;
      READ:    if (w_last_addr)      w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_end)      w_state_nxt = DONE;
      DONE:                          w_state_nxt = IDLE;
      default:                       w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_addr      <= (w_rd_en && !w_last_addr) ? r_addr + ADDR_W'(1) : '0;
      r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 3'd1 : 3'd0;
    end
  end

  // Stage p0..p(RD_LAT-1): read tag travels alongside the RAM access latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p <= '0;
      for (int i = 0; i < RD_LAT; i++) r_idx_p[i] <= '0;
    end else begin
      r_vld_p[0] <= w_rd_en;
      r_idx_p[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        r_idx_p[i] <= r_idx_p[i-1];
      end
    end
  end

  // Compare stage: tagged sample meets the running maximum
  always_comb begin
    w_best_val_nxt = r_best_val;
    w_best_idx_nxt = r_best_idx;
    if (w_vld && beats(w_rdata, r_best_val, w_idx == '0)) begin
      w_best_val_nxt = w_rdata;
      w_best_idx_nxt = w_idx;
    end
  end

  always_ff @(posedge clk) begin
    r_best_val <= w_best_val_nxt;
    r_best_idx <= w_best_idx_nxt;
  end

  // Result stage: the final sample lands on the same edge that enters DONE, so take the next-state view
`ifdef FC_ARGMAX_SCORE_EN
  logic [DATA_W-1:0] r_max_score;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_max_score <= '0;
    else if (r_state == DRAIN && w_drain_end) r_max_score <= w_best_val_nxt;
  end
  assign bus.max_score = r_max_score;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_class_id <= '0;
    else if (r_state == DRAIN && w_drain_end) r_class_id <= w_best_idx_nxt;
  end

  assign bus.f8_rd_en    = w_rd_en;
  assign bus.f8_raddr    = r_addr;
  assign bus.busy        = (r_state != IDLE);
  assign bus.argmax_done = (r_state == DONE);
  assign bus.class_id    = r_class_id;

endmodule

// File: doc/fc_argmax.md
# fc_argmax

Classification stage downstream of the final fully-connected layer. After the FC3 controller signals completion, this block reads the N_CLASS signed scores from the f8 result RAM one per cycle. It tracks the running maximum and reports the index of the largest score as the network's predicted class. It emits a one-cycle done pulse and holds the result until the next run.

## Interface
- DATA_W, 16, width of one signed f8 score (two's complement)
- N_CLASS, 10, number of scores to scan (addresses 0..N_CLASS-1)
- ADDR_W, 4, f8 read-address and class_id width; must satisfy 2^ADDR_W >= N_CLASS
- RD_LAT, 1, f8 RAM read latency in cycles (1..4); f8_rdata is valid RD_LAT cycles after f8_rd_en

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- argmax_start  input  1  start pulse; driven by the FC3 done pulse; sampled only in IDLE
- f8_rd_en  output  1  f8 RAM read enable
- f8_raddr  output  ADDR_W  f8 RAM read address
- f8_rdata  input  DATA_W  signed score returned by f8 RAM
- busy  output  1  high in every state except IDLE
- argmax_done  output  1  one-cycle pulse; class_id is valid in the same cycle
- class_id  output  ADDR_W  index of the maximum score; held until the next accepted start
- max_score  output  DATA_W  maximum score value (only with FC_ARGMAX_SCORE_EN)

## Operation
- FSM states: IDLE, READ, DRAIN, DONE (one-hot).
- IDLE -> READ on argmax_start=1.
- READ -> DRAIN when the address counter reaches N_CLASS-1. That cycle still issues its read.
- DRAIN -> DONE after RD_LAT cycles.
- DONE -> IDLE unconditionally after one cycle.
- argmax_start is ignored in READ, DRAIN and DONE. No queuing.
- Address counter: 0 on entry to READ. Increments by 1 every READ cycle. Cleared to 0 on leaving READ.
- f8_rd_en = (state==READ). f8_raddr = counter. f8_raddr is 0 outside READ.
- Returned data is tagged by an RD_LAT-deep shift register of {rd_en, raddr}. A sample is consumed when the tag's valid bit is 1.
- First consumed sample of a run (index 0) loads best_val/best_idx unconditionally.
- Each later sample replaces best_val/best_idx only if it is strictly greater, using a signed compare over the full DATA_W.
- Ties keep the lower index.
- There is no arithmetic, so no overflow is possible. The most negative value (e.g. 0x8000) is a legal score.
- class_id is updated from best_idx on entry to DONE. It is not updated mid-scan; the previous result remains visible while busy.

## Timing
- Cycle 0: argmax_start sampled high in IDLE.
- Cycles 1..N_CLASS: READ, addresses 0..N_CLASS-1, one per cycle.
- Last sample is consumed at the end of cycle N_CLASS+RD_LAT.
- argmax_done is high in cycle N_CLASS+RD_LAT+1. With defaults this is cycle 12.
- busy is high for cycles 1..N_CLASS+RD_LAT+1.
- A new start is accepted from cycle N_CLASS+RD_LAT+2 onward. Back-to-back runs have no dead cycle beyond the IDLE sample.
- Reset values: state=IDLE, busy=0, f8_rd_en=0, f8_raddr=0, argmax_done=0, class_id=0, max_score=0, tag pipeline cleared.
- rst_n asserted mid-run aborts immediately. All outputs return to reset values. No done pulse is produced for the aborted run.
- argmax_start held high continuously starts a new run every N_CLASS+RD_LAT+2 cycles.

## Configuration
- FC_ARGMAX_SCORE_EN defined: the max_score port exists. It is registered from best_val on entry to DONE and held with class_id.
- FC_ARGMAX_SCORE_EN undefined: the max_score port and its register are absent. best_val remains internal. class_id and timing are unchanged.

## Test plan
- Scores {3,-5,7,1,0,2,-1,6,4,5}, RD_LAT=1 -> argmax_done in cycle 12, class_id=2, max_score=7; f8_raddr sequence 0..9 in cycles 1..10.
- All scores 0x8000 (most negative) -> class_id=0, max_score=0x8000. Checks unconditional first load and tie rule.
- Tie {1,9,4,9,0,0,0,0,0,9} -> class_id=1. Maximum in the last slot {0,...,0,100} -> class_id=9.
- RD_LAT=3, scores with the max at index 5 -> done in cycle 14, class_id=5. No sample is dropped or misaligned.
- argmax_start pulsed in cycles 4 and 11 during a run -> ignored; exactly one done pulse. rst_n low in cycle 6 -> outputs return to reset values and no done pulse occurs. A restart after reset gives the correct result.
- Two back-to-back runs with different data -> class_id holds the first result until the second done pulse, then changes in that exact cycle.
